// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared types and helpers for the APB arbitrating master.
package apb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam int APB_MAX_SLAVES = 16;
    localparam int APB_SEL_W = 4;
    typedef struct packed {
        logic                 write;
        logic                 dec_err;
        logic [APB_SEL_W-1:0] sel;
    } req_meta_t;
    function automatic logic [APB_MAX_SLAVES-1:0] sel_onehot(input logic [APB_SEL_W-1:0] idx);
        return APB_MAX_SLAVES'(1) << idx;
    endfunction
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin grant over NUM_REQ requests; pointer advances past the winner on accept.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       pclock,
    input  logic                       preset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_accept,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] r_ptr;
    // Scan from farthest to nearest offset so the first set bit at/after the pointer wins.
    always_comb begin
        int j;
        j = 0;
        o_grant = '0;
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (i_req[j]) begin
                o_grant = NUM_REQ'(1) << j;
                o_idx = IW'(j);
            end
        end
    end
    always_ff @(posedge pclock or posedge preset)
        if (preset) r_ptr <= '0;
        else if (i_accept) r_ptr <= IW'((int'(o_idx) + 1) % NUM_REQ);
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin arbitrated APB master (IDLE -> SETUP -> ACCESS), all outputs registered.
// Define APB_TIMEOUT_EN to terminate ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_arb_master
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int PADDR_WIDTH    = 32,
    parameter int PDATA_WIDTH    = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           pclock,
    input  logic                           preset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*PDATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [PDATA_WIDTH-1:0]         rsp_rdata,
    output logic                           rsp_err,
    output logic [PADDR_WIDTH-1:0]         paddr,
    output logic                           prwd,
    output logic [PDATA_WIDTH-1:0]         pwdata,
    output logic                           penable,
    output logic [APB_MAX_SLAVES-1:0]      psel,
    input  logic [PDATA_WIDTH-1:0]         prdata,
    input  logic                           pready,
    input  logic                           pslverr
);
    state_t                     r_state;
    req_meta_t                  r_meta;
    logic [NUM_REQ-1:0]         r_gnt;
    logic [PADDR_WIDTH-1:0]     r_addr;
    logic [PDATA_WIDTH-1:0]     r_wdata;
    logic [NUM_REQ-1:0]         w_gnt;
    logic [$clog2(NUM_REQ)-1:0] w_gidx;
    logic [PADDR_WIDTH-1:0]     w_addr;
    logic [PDATA_WIDTH-1:0]     w_wdata;
    logic                       w_write;
    logic                       w_accept;
    logic [APB_SEL_W-1:0]       w_sel;
    logic                       w_dec_ok;
`ifdef APB_TIMEOUT_EN
    logic [15:0]                r_tcnt;
`endif
    assign w_accept = (r_state == IDLE) && (|req_valid);
    assign w_sel = w_addr[SEL_LSB +: APB_SEL_W];
    assign w_dec_ok = int'(w_sel) < NUM_SLAVES;
    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .pclock  (pclock),
        .preset  (preset),
        .i_req   (req_valid),
        .i_accept(w_accept),
        .o_grant (w_gnt),
        .o_idx   (w_gidx)
    );
    always_comb begin
        w_addr = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (int'(w_gidx) == i) begin
                w_addr = req_addr[i*PADDR_WIDTH +: PADDR_WIDTH];
                w_wdata = req_wdata[i*PDATA_WIDTH +: PDATA_WIDTH];
                w_write = req_write[i];
            end
    end
    always_ff @(posedge pclock or posedge preset)
        if (preset) begin
            r_state <= IDLE;
            r_meta <= '0;
            r_gnt <= '0;
            r_addr <= '0;
            r_wdata <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            paddr <= '0;
            prwd <= 1'b0;
            pwdata <= '0;
            penable <= 1'b0;
            psel <= '0;
`ifdef APB_TIMEOUT_EN
            r_tcnt <= '0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (r_state)
                IDLE:
                    if (w_accept) begin
                        req_ready <= w_gnt;
                        r_gnt <= w_gnt;
                        r_addr <= w_addr;
                        r_wdata <= w_wdata;
                        r_meta <= '{write: w_write, dec_err: !w_dec_ok, sel: w_sel};
                        r_state <= SETUP;
                    end
                SETUP:
                    if (r_meta.dec_err) begin
                        rsp_valid <= r_gnt;
                        rsp_err <= 1'b1;
                        rsp_rdata <= '0;
                        r_state <= IDLE;
                    end else begin
                        psel <= sel_onehot(r_meta.sel);
                        paddr <= r_addr;
                        prwd <= r_meta.write;
                        pwdata <= r_wdata;
                        r_state <= ACCESS;
`ifdef APB_TIMEOUT_EN
                        r_tcnt <= '0;
`endif
                    end
                ACCESS:
                    // First ACCESS cycle only raises penable; pready is meaningful afterwards.
                    if (!penable) penable <= 1'b1;
                    else if (pready) begin
                        psel <= '0;
                        penable <= 1'b0;
                        rsp_valid <= r_gnt;
                        rsp_err <= pslverr;
                        rsp_rdata <= (r_meta.write || pslverr) ? '0 : prdata;
                        r_state <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        psel <= '0;
                        penable <= 1'b0;
                        rsp_valid <= r_gnt;
                        rsp_err <= 1'b1;
                        rsp_rdata <= '0;
                        r_state <= IDLE;
                    end else r_tcnt <= r_tcnt + 16'd1;
`endif
                default: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed bench with response scoreboard and a wait-state APB slave model.
module tb_apb_arb_master;
    logic         pclock = 1'b0;
    logic         preset;
    logic [3:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  rsp_rdata, paddr, pwdata, prdata;
    logic         rsp_err, prwd, penable, pready, pslverr;
    logic [15:0]  psel;
    int           cfg_wait;
    logic         cfg_err, cfg_stuck;
    logic [31:0]  cfg_rdata;
    int           wcnt = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t m_e;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int acc_run = 0, acc_last = 0, psel_cycles = 0;
    logic [15:0] s_psel;
    logic [31:0] s_paddr, s_pwdata;
    logic        s_prwd;

    always #5 pclock = ~pclock;
    always @(posedge pclock) cyc++;

    assign pready  = penable && !cfg_stuck && (wcnt >= cfg_wait);
    assign pslverr = cfg_err && pready;
    assign prdata  = cfg_rdata;
    always @(posedge pclock) wcnt <= (penable && !pready) ? wcnt + 1 : 0;

    apb_arb_master #(
        .NUM_REQ(4), .PADDR_WIDTH(32), .PDATA_WIDTH(32),
        .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYCLES(8)
    ) dut (
        .pclock(pclock), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .penable(penable), .psel(psel),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclock);
    endtask

    task automatic wait_grant(output int g, output int gc);
        g = -1;
        gc = 0;
        for (int i = 0; i < 50 && g < 0; i++) begin
            @(negedge pclock);
            for (int k = 0; k < 4; k++) if (req_ready[k]) begin g = k; gc = cyc; end
        end
        if (g < 0) chk("grant_timeout", 64'(req_ready != 0), 64'd1);
    endtask

    task automatic wait_rsp(input int max);
        bit seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge pclock);
            seen = (rsp_valid != 0);
        end
        if (!seen) chk("rsp_timeout", 64'(rsp_valid != 0), 64'd1);
    endtask

    // Monitor: scoreboard responses, track ACCESS length and bus stability.
    always @(negedge pclock) begin
        if (rsp_valid !== 4'b0) begin
            acc_last = acc_run;
            if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            else begin
                m_e = sb.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(1) << m_e.idx);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
            end
        end
        if (psel != 0) psel_cycles++;
        if (penable) begin
            acc_run++;
            chk("stable_psel", 64'(psel), 64'(s_psel));
            chk("stable_paddr", 64'(paddr), 64'(s_paddr));
            chk("stable_pwdata", 64'(pwdata), 64'(s_pwdata));
            chk("stable_prwd", 64'(prwd), 64'(s_prwd));
        end else begin
            acc_run = 0;
            s_psel = psel;
            s_paddr = paddr;
            s_pwdata = pwdata;
            s_prwd = prwd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, gc, prev, pc;
        preset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        cfg_wait = 0; cfg_err = 1'b0; cfg_stuck = 1'b0; cfg_rdata = 32'h1234_0000;
        tick(3);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_prwd", 64'(prwd), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        preset = 1'b0;
        tick(2);

        // Reset in the middle of an ACCESS phase aborts without a response.
        req_addr[31:0] = 32'h0000_2000;
        cfg_wait = 20;
        req_valid = 4'b0001;
        wait_grant(g, gc);
        chk("abort_grant", 64'(g), 64'd0);
        req_valid = '0;
        for (int i = 0; i < 10 && !penable; i++) @(negedge pclock);
        chk("abort_in_access", 64'(penable), 64'd1);
        #2 preset = 1'b1;
        @(negedge pclock);
        chk("abort_psel", 64'(psel), 64'd0);
        chk("abort_penable", 64'(penable), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        preset = 1'b0;
        cfg_wait = 0;
        tick(3);

        // Fairness: all requesters held, grants rotate 0,1,2,3,0 every 4 cycles.
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'(i * 32'h1000);
        for (int k = 0; k < 5; k++) sb.push_back('{idx: k % 4, rdata: 32'h1234_0000, err: 1'b0});
        req_valid = 4'hF;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, gc);
            chk("fair_grant", 64'(g), 64'(k % 4));
            if (k > 0) chk("fair_gap", 64'(gc - prev), 64'd4);
            prev = gc;
            if (k == 4) req_valid = '0;
        end
        wait_rsp(20);
        tick(1);

        // Zero-wait write.
        req_addr[31:0] = 32'h0000_1004;
        req_wdata[31:0] = 32'hA5A5_0001;
        req_write = 4'b0001;
        sb.push_back('{idx: 0, rdata: 32'h0, err: 1'b0});
        req_valid = 4'b0001;
        wait_grant(g, gc);
        chk("wr_grant", 64'(g), 64'd0);
        req_valid = '0;
        tick(1);
        chk("wr_setup_psel", 64'(psel), 64'h0002);
        chk("wr_setup_penable", 64'(penable), 64'd0);
        chk("wr_setup_paddr", 64'(paddr), 64'h0000_1004);
        chk("wr_setup_pwdata", 64'(pwdata), 64'hA5A5_0001);
        chk("wr_setup_prwd", 64'(prwd), 64'd1);
        tick(1);
        chk("wr_access_penable", 64'(penable), 64'd1);
        chk("wr_access_psel", 64'(psel), 64'h0002);
        tick(1);
        chk("wr_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("wr_latency", 64'(cyc - gc), 64'd3);
        req_write = '0;
        tick(1);

        // Wait-state read on requester 2.
        req_addr[95:64] = 32'h0000_3000;
        cfg_wait = 5;
        cfg_rdata = 32'hDEAD_BEEF;
        sb.push_back('{idx: 2, rdata: 32'hDEAD_BEEF, err: 1'b0});
        req_valid = 4'b0100;
        wait_grant(g, gc);
        chk("rd_grant", 64'(g), 64'd2);
        req_valid = '0;
        wait_rsp(30);
        chk("rd_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        tick(1);
        chk("rd_access_cycles", 64'(acc_last), 64'd6);
        cfg_wait = 0;

        // Slave error.
        req_addr[63:32] = 32'h0000_1000;
        cfg_err = 1'b1;
        sb.push_back('{idx: 1, rdata: 32'h0, err: 1'b1});
        req_valid = 4'b0010;
        wait_grant(g, gc);
        chk("slverr_grant", 64'(g), 64'd1);
        req_valid = '0;
        wait_rsp(20);
        chk("slverr_err", 64'(rsp_err), 64'd1);
        cfg_err = 1'b0;
        tick(1);

        // Decode error: slave index 5 with only 4 slaves populated.
        req_addr[127:96] = 32'h0000_5000;
        pc = psel_cycles;
        sb.push_back('{idx: 3, rdata: 32'h0, err: 1'b1});
        req_valid = 4'b1000;
        wait_grant(g, gc);
        chk("dec_grant", 64'(g), 64'd3);
        req_valid = '0;
        wait_rsp(10);
        chk("dec_latency", 64'(cyc - gc), 64'd1);
        tick(2);
        chk("dec_no_psel", 64'(psel_cycles), 64'(pc));

`ifdef APB_TIMEOUT_EN
        // Stuck slave is abandoned after 8 ACCESS cycles.
        req_addr[31:0] = 32'h0000_2000;
        cfg_stuck = 1'b1;
        sb.push_back('{idx: 0, rdata: 32'h0, err: 1'b1});
        req_valid = 4'b0001;
        wait_grant(g, gc);
        chk("to_grant", 64'(g), 64'd0);
        req_valid = '0;
        wait_rsp(40);
        tick(1);
        chk("to_access_cycles", 64'(acc_last), 64'd8);
        chk("to_psel", 64'(psel), 64'd0);
        cfg_stuck = 1'b0;
`endif

        tick(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
